// File: rtl/axil_dma_regs.sv
// AXI4-Lite register block for a simple DMA core: descriptor, control, status.
// Optional byte strobes: define AXIL_DMA_REGS_WSTRB_EN.
module axil_dma_regs #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    dma_start,
    output logic [31:0]             src_addr,
    output logic [31:0]             dst_addr,
    output logic [31:0]             xfer_len,
    input  logic                    dma_busy,
    input  logic                    dma_done,
    output logic                    irq
);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                    rdy_q, rdy_d;
    logic                    aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                    w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    irq_en_q, irq_en_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    start_q, start_d;
    logic [31:0]             src_q, src_d;
    logic [31:0]             dst_q, dst_d;
    logic [31:0]             len_q, len_d;

    logic                    commit;
    logic [2:0]              w_idx;
    logic                    w_ok;
    logic [2:0]              r_idx;
    logic                    r_map;
    logic [31:0]             rd_val;
    logic [31:0]             mask;
    logic                    w1c;
    logic                    unused_bits;

`ifdef AXIL_DMA_REGS_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    assign unused_bits = ^{awaddr_q[1:0], araddr[1:0]};
`else
    assign unused_bits = ^{awaddr_q[1:0], araddr[1:0], wstrb};
`endif

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    // Readies are held low until the first edge after reset releases.
    assign awready   = rdy_q && !aw_held_q && !bvalid_q;
    assign wready    = rdy_q && !w_held_q && !bvalid_q;
    assign arready   = rdy_q && !rvalid_q;
    assign bvalid    = bvalid_q;
    assign bresp     = bresp_q;
    assign rvalid    = rvalid_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign dma_start = start_q;
    assign src_addr  = src_q;
    assign dst_addr  = dst_q;
    assign xfer_len  = len_q;
    assign irq       = done_q && irq_en_q;

    assign commit = aw_held_q && w_held_q && !bvalid_q;
    assign w_idx  = awaddr_q[4:2];
    assign w_ok   = (awaddr_q[ADDR_WIDTH-1:5] == '0) && (w_idx < 3'd5);
    assign r_idx  = araddr[4:2];
    assign r_map  = (araddr[ADDR_WIDTH-1:5] == '0) && (r_idx < 3'd6);

    // Byte-enable mask applied to the committed write data.
    always_comb begin
        mask = '1;
`ifdef AXIL_DMA_REGS_WSTRB_EN
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{wstrb_q[i]}};
        end
`endif
    end

    // Read mux over the current (pre-edge) register values.
    always_comb begin
        rd_val = '0;
        if (r_map) begin
            unique case (1'b1)
                (r_idx == 3'd0): rd_val = {30'b0, irq_en_q, 1'b0};
                (r_idx == 3'd1): rd_val = {30'b0, done_q, busy_q};
                (r_idx == 3'd2): rd_val = src_q;
                (r_idx == 3'd3): rd_val = dst_q;
                (r_idx == 3'd4): rd_val = len_q;
                default:         rd_val = VERSION;
            endcase
        end
    end

    // Next state: channel handshakes, write commit, status and read capture.
    always_comb begin
        rdy_d     = 1'b1;
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
`ifdef AXIL_DMA_REGS_WSTRB_EN
        wstrb_d   = wstrb_q;
`endif
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        irq_en_d  = irq_en_q;
        busy_d    = dma_busy;
        start_d   = 1'b0;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        w1c       = 1'b0;

        if (awvalid && awready) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
        end
        if (wvalid && wready) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
`ifdef AXIL_DMA_REGS_WSTRB_EN
            wstrb_d  = wstrb;
`endif
        end
        if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_ok ? OKAY : SLVERR;
            if (w_ok) begin
                unique case (1'b1)
                    (w_idx == 3'd0): begin
                        if (mask[1]) irq_en_d = wdata_q[1];
                        start_d = mask[0] && wdata_q[0] &&
                                  !dma_busy && (len_q != '0);
                    end
                    (w_idx == 3'd1): w1c = mask[1] && wdata_q[1];
                    (w_idx == 3'd2): src_d = merge(src_q, wdata_q, mask);
                    (w_idx == 3'd3): dst_d = merge(dst_q, wdata_q, mask);
                    default:         len_d = merge(len_q, wdata_q, mask);
                endcase
            end
        end

        // A done pulse wins over a coincident clear.
        done_d = dma_done ? 1'b1 : (w1c ? 1'b0 : done_q);

        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
        if (arvalid && arready) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = r_map ? OKAY : SLVERR;
        end
    end

    // State registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q     <= 1'b0;
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
`ifdef AXIL_DMA_REGS_WSTRB_EN
            wstrb_q   <= '0;
`endif
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
        end else begin
            rdy_q     <= rdy_d;
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
`ifdef AXIL_DMA_REGS_WSTRB_EN
            wstrb_q   <= wstrb_d;
`endif
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
        end
    end

endmodule

// File: tb/tb_axil_dma_regs.sv
// Randomized bench for axil_dma_regs against a transaction-level register model.
// Honours AXIL_DMA_REGS_WSTRB_EN the same way as the design build.
module tb_axil_dma_regs;

    logic        clk;
    logic        rst;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        dma_start;
    logic [31:0] src_addr, dst_addr, xfer_len;
    logic        dma_busy, dma_done;
    logic        irq;

    axil_dma_regs dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .dma_start(dma_start), .src_addr(src_addr), .dst_addr(dst_addr),
        .xfer_len(xfer_len), .dma_busy(dma_busy), .dma_done(dma_done),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int starts = 0;
    bit chk_on = 0;

    // Register model
    logic [31:0] m_src = 0, m_dst = 0, m_len = 0;
    bit m_ie = 0, m_done = 0, m_busy = 0, exp_start = 0;
    bit cm_pend = 0;
    logic [31:0] cm_a, cm_d;
    logic [3:0] cm_s;
    bit rand_side = 0, done_on_commit = 0;

    logic [31:0] tbl [10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10,
                              32'h14, 32'h18, 32'h1C, 32'h20, 32'h1000_0008};

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] smask(input logic [3:0] s);
        logic [31:0] m;
        m = '1;
`ifdef AXIL_DMA_REGS_WSTRB_EN
        for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
`endif
        return m;
    endfunction

    function automatic bit wr_ok(input logic [31:0] a);
        return (a < 32'h18) && (a[4:2] != 3'd5);
    endfunction

    function automatic logic [33:0] mrd(input logic [31:0] a);
        if (a >= 32'h18) return {2'b10, 32'h0};
        case (a[4:2])
            3'd0: return {2'b00, 30'h0, m_ie, 1'b0};
            3'd1: return {2'b00, 30'h0, m_done, m_busy};
            3'd2: return {2'b00, m_src};
            3'd3: return {2'b00, m_dst};
            3'd4: return {2'b00, m_len};
            default: return {2'b00, 32'h0001_0000};
        endcase
    endfunction

    // Advance one clock; the model takes the effect of that edge.
    task automatic tick();
        bit st, w1c, nie, ndone, nbusy;
        logic [31:0] mk, nsrc, ndst, nlen;
        st = 0; w1c = 0;
        nie = m_ie; nsrc = m_src; ndst = m_dst; nlen = m_len;
        if (rand_side) begin
            if ($urandom_range(0, 9) == 0) dma_busy = ~dma_busy;
            dma_done = ($urandom_range(0, 7) == 0);
        end
        if (cm_pend && done_on_commit) dma_done = 1'b1;
        if (cm_pend && wr_ok(cm_a)) begin
            mk = smask(cm_s);
            case (cm_a[4:2])
                3'd0: begin
                    if (mk[1]) nie = cm_d[1];
                    st = mk[0] && cm_d[0] && !dma_busy && (m_len != 0);
                end
                3'd1: w1c = mk[1] && cm_d[1];
                3'd2: nsrc = (m_src & ~mk) | (cm_d & mk);
                3'd3: ndst = (m_dst & ~mk) | (cm_d & mk);
                default: nlen = (m_len & ~mk) | (cm_d & mk);
            endcase
        end
        ndone = dma_done ? 1'b1 : (w1c ? 1'b0 : m_done);
        nbusy = dma_busy;
        @(posedge clk);
        m_ie = nie; m_done = ndone; m_busy = nbusy;
        m_src = nsrc; m_dst = ndst; m_len = nlen;
        exp_start = st; cm_pend = 0;
        #1;
        dma_done = 1'b0;
    endtask

    // Per-cycle comparison of the sideband outputs.
    always @(negedge clk) begin
        if (!rst && chk_on) begin
            chk("irq", irq, m_ie && m_done);
            chk("dma_start", dma_start, exp_start);
            chk("src_addr", src_addr, m_src);
            chk("dst_addr", dst_addr, m_dst);
            chk("xfer_len", xfer_len, m_len);
            if (dma_start) starts++;
        end
    end

    task automatic hs_wait(input bit aw, input bit w, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if ((!aw || awready) && (!w || wready)) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int order,
                            input int bdly, input bit rdc,
                            output logic [1:0] br, output logic [31:0] rdv);
        bit ok, okp, isaw;
        logic [33:0] rexp;
        logic [1:0] bexp;
        bexp = wr_ok(a) ? 2'b00 : 2'b10;
        awaddr = a; wdata = d; wstrb = s;
        ok = 1; br = 2'b11; rdv = 32'hDEAD_BEEF;
        if (order == 2) begin
            awvalid = 1; wvalid = 1;
            hs_wait(1, 1, okp);
            ok &= okp;
            if (okp) tick();
            awvalid = 0; wvalid = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                isaw = ((p == 0) == (order == 0));
                if (isaw) awvalid = 1; else wvalid = 1;
                hs_wait(isaw, !isaw, okp);
                ok &= okp;
                if (okp) tick();
                awvalid = 0; wvalid = 0;
                if (p == 0) repeat ($urandom_range(0, 2)) tick();
            end
        end
        if (!ok) begin
            chk("aw_w_handshake_timeout", 0, 1);
            return;
        end
        cm_pend = 1; cm_a = a; cm_d = d; cm_s = s;
        rexp = mrd(a);
        if (rdc) begin
            arvalid = 1; araddr = a;
        end
        tick();
        arvalid = 0;
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, bexp);
        br = bresp;
        if (rdc) begin
            chk("rvalid_on_commit", rvalid, 1);
            chk("rdata_on_commit", rdata, rexp[31:0]);
            rdv = rdata;
            rready = 1; tick(); rready = 0;
            chk("rvalid_clear", rvalid, 0);
        end
        for (int k = 0; k < bdly; k++) begin
            tick();
            chk("b_hold", {bvalid, awready, wready}, 3'b100);
        end
        bready = 1; tick(); bready = 0;
        chk("b_clear", bvalid, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input int rdly,
                           output logic [31:0] d, output logic [1:0] r);
        bit ok;
        logic [33:0] exp;
        arvalid = 1; araddr = a; ok = 0;
        d = 32'hDEAD_BEEF; r = 2'b11;
        for (int i = 0; i < 20; i++) begin
            if (arready) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            arvalid = 0;
            chk("ar_handshake_timeout", 0, 1);
            return;
        end
        exp = mrd(a);
        tick();
        arvalid = 0;
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, exp[31:0]);
        chk("rresp", rresp, exp[33:32]);
        d = rdata; r = rresp;
        for (int k = 0; k < rdly; k++) begin
            tick();
            chk("r_hold", {rvalid, rdata}, {1'b1, d});
        end
        rready = 1; tick(); rready = 0;
        chk("r_clear", rvalid, 0);
    endtask

    task automatic model_reset();
        m_src = 0; m_dst = 0; m_len = 0;
        m_ie = 0; m_done = 0; m_busy = 0; exp_start = 0; cm_pend = 0;
    endtask

    logic [1:0]  br, rr;
    logic [31:0] rd, rdv, a, d;
    int sc0;

    initial begin
        rst = 1;
        awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0; arvalid = 0; araddr = 0; rready = 0;
        dma_busy = 0; dma_done = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {awready, wready, arready, bvalid, rvalid,
                         dma_start, irq}, 7'h0);
        chk("rst_resp", {bresp, rresp}, 4'h0);
        chk("rst_rdata", rdata, 0);
        rst = 0;
        #1;
        chk("ready_before_edge", {awready, wready, arready}, 3'b000);
        tick();
        chk("ready_after_edge", {awready, wready, arready}, 3'b111);
        chk_on = 1;

        do_read(32'h8, 0, rd, rr);
        chk("src_reset", rd, 32'h0);

        do_write(32'h8, 32'h1000_0000, 4'hF, 0, 0, 0, br, rdv);
        chk("src_bresp", br, 2'b00);
        do_read(32'h8, 2, rd, rr);
        chk("src_read", rd, 32'h1000_0000);
        chk("src_rresp", rr, 2'b00);

        do_write(32'h8, 32'h2222_0000, 4'hF, 2, 0, 1, br, rdv);
        chk("read_on_commit_old", rdv, 32'h1000_0000);
        do_read(32'h8, 0, rd, rr);
        chk("src_new", rd, 32'h2222_0000);

        do_write(32'h10, 32'h40, 4'hF, 1, 5, 0, br, rdv);
        sc0 = starts;
        do_write(32'h0, 32'h1, 4'hF, 0, 0, 0, br, rdv);
        repeat (2) tick();
        chk("start_pulse_cnt", starts - sc0, 1);
        dma_busy = 1;
        tick();
        sc0 = starts;
        do_write(32'h0, 32'h1, 4'hF, 2, 0, 0, br, rdv);
        repeat (2) tick();
        chk("start_busy_cnt", starts - sc0, 0);
        chk("start_busy_bresp", br, 2'b00);
        do_read(32'h4, 0, rd, rr);
        chk("status_busy", rd, 32'h1);
        dma_busy = 0;
        tick();

        do_write(32'h0, 32'h2, 4'hF, 0, 0, 0, br, rdv);
        dma_done = 1;
        tick();
        chk("irq_set", irq, 1);
        do_read(32'h4, 0, rd, rr);
        chk("status_done", rd, 32'h2);
        do_write(32'h4, 32'h2, 4'hF, 1, 0, 0, br, rdv);
        chk("irq_w1c", irq, 0);
        dma_done = 1;
        tick();
        done_on_commit = 1;
        do_write(32'h4, 32'h2, 4'hF, 2, 0, 0, br, rdv);
        done_on_commit = 0;
        do_read(32'h4, 0, rd, rr);
        chk("done_set_wins", rd, 32'h2);
        chk("irq_still", irq, 1);

        do_write(32'h14, 32'h5555_5555, 4'hF, 2, 0, 0, br, rdv);
        chk("ver_wr_slverr", br, 2'b10);
        do_write(32'h20, 32'h5555_5555, 4'hF, 0, 0, 0, br, rdv);
        chk("unmap_wr_slverr", br, 2'b10);
        do_read(32'h20, 0, rd, rr);
        chk("unmap_rdata", rd, 32'h0);
        chk("unmap_rresp", rr, 2'b10);
        do_read(32'h14, 0, rd, rr);
        chk("version", rd, 32'h0001_0000);

        do_write(32'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, br, rdv);
        do_write(32'hC, 32'h1234_5678, 4'b0011, 1, 0, 0, br, rdv);
        do_read(32'hC, 0, rd, rr);
`ifdef AXIL_DMA_REGS_WSTRB_EN
        chk("dst_strobe", rd, 32'hFFFF_5678);
`else
        chk("dst_strobe", rd, 32'h1234_5678);
`endif

        rand_side = 1;
        for (int n = 0; n < 250; n++) begin
            a = tbl[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                if ($urandom_range(0, 3) == 0) d = d & 32'h3;
                do_write(a, d, 4'($urandom), $urandom_range(0, 2),
                         $urandom_range(0, 3), $urandom_range(0, 5) == 0,
                         br, rdv);
            end else begin
                do_read(a, $urandom_range(0, 3), rd, rr);
            end
        end
        rand_side = 0;
        dma_busy = 0;
        tick();

        awaddr = 32'h8; wdata = 32'hAAAA_0000; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; arvalid = 1; araddr = 32'h14;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        cm_pend = 1; cm_a = 32'h8; cm_d = 32'hAAAA_0000; cm_s = 4'hF;
        tick();
        chk("mid_valids", {bvalid, rvalid}, 2'b11);
        rst = 1;
        model_reset();
        #1;
        chk("mid_rst_outs", {awready, wready, arready, bvalid, rvalid,
                             dma_start, irq}, 7'h0);
        chk("mid_rst_resp", {bresp, rresp}, 4'h0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_src", src_addr, 0);
        #1;
        rst = 0;
        #1;
        chk("mid_ready_before_edge", arready, 0);
        tick();
        chk("mid_ready_after_edge", {awready, wready, arready}, 3'b111);
        tick();
        chk("dropped_no_resp", {bvalid, rvalid}, 2'b00);
        do_read(32'h8, 0, rd, rr);
        chk("src_after_rst", rd, 32'h0);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axil_dma_regs.md
AXIL_DMA_REGS -- requirements
Module: axil_dma_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-003 SHALL have parameter VERSION, default 32'h0001_0000, value returned by the VERSION register.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 awvalid/awready/awaddr  in/out/in  1/1/ADDR_WIDTH  write address channel.
REQ-007 wvalid/wready/wdata/wstrb  in/out/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel.
REQ-008 bvalid/bready/bresp  out/in/out  1/1/2  write response channel.
REQ-009 arvalid/arready/araddr  in/out/in  1/1/ADDR_WIDTH  read address channel.
REQ-010 rvalid/rready/rdata/rresp  out/in/out/out  1/1/DATA_WIDTH/2  read data channel.
REQ-011 dma_start  output  1  one-cycle start pulse to DMA core.
REQ-012 src_addr, dst_addr, xfer_len  output  32 each  transfer descriptor to DMA core.
REQ-013 dma_busy, dma_done  input  1 each  core busy level; done one-cycle pulse.
REQ-014 irq  output  1  interrupt level = STATUS.done AND CTRL.irq_en.

Function
REQ-015 Register map (addr[4:2]): 0x00 CTRL {bit1 irq_en RW, bit0 start W1 self-clearing, reads 0}; 0x04 STATUS {bit1 done W1C, bit0 busy RO}; 0x08 SRC RW; 0x0C DST RW; 0x10 LEN RW; 0x14 VERSION RO.
REQ-016 addr[1:0] ignored; addr >= 0x18 is unmapped.
REQ-017 AW and W accepted independently, any order or same cycle: awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
REQ-018 On handshake, address/data latched and aw_held/w_held set.
REQ-019 Commit cycle: aw_held && w_held && !bvalid -> register update on that edge, bvalid=1 next cycle, held flags cleared.
REQ-020 bvalid held until bready; bresp = 2'b00 OKAY, 2'b10 SLVERR for unmapped or write to VERSION (no state change).
REQ-021 Read: arready = !rvalid; on AR handshake, rvalid=1 next cycle with rdata/rresp registered; held stable until rready.
REQ-022 Unmapped read -> rdata 0, rresp 2'b10; mapped -> 2'b00.
REQ-023 Read and write paths independent; simultaneous read and write commit allowed; a read on the commit edge returns the pre-write value.
REQ-024 Write CTRL with bit0=1 -> dma_start=1 for exactly one cycle after commit, only if dma_busy=0 and LEN!=0; otherwise ignored, response still OKAY.
REQ-025 dma_done pulse sets STATUS.done; done pulse and W1C on same edge -> done stays 1 (set wins).
REQ-026 STATUS.busy reads dma_busy sampled through one register stage.
REQ-027 SRC/DST/LEN writes while dma_busy=1 are applied; the core samples them only on dma_start.

Reset
REQ-028 rst asserted -> awready, wready, arready, bvalid, rvalid, dma_start, irq = 0 asynchronously; bresp, rresp, rdata = 0.
REQ-029 rst -> CTRL, STATUS.done, SRC, DST, LEN = 0; held flags cleared; an in-flight transaction is dropped with no response.
REQ-030 awready/wready/arready rise on the first clk edge after rst deasserts.

Configuration
REQ-031 Macro AXIL_DMA_REGS_WSTRB_EN defined: RW register bytes updated only where wstrb bit = 1; W1 and W1C bits act only if the strobe of their byte = 1.
REQ-032 AXIL_DMA_REGS_WSTRB_EN undefined: wstrb port present but ignored; every write is a full 32-bit write.

Verification
REQ-033 Write SRC=0x1000_0000 (AW then W on separate cycles) -> bresp OKAY; read 0x08 -> 0x1000_0000, rresp OKAY.
REQ-034 LEN=0x40, write CTRL=0x1 with dma_busy=0 -> dma_start high exactly 1 cycle; repeat with dma_busy=1 -> no pulse.
REQ-035 CTRL=0x2, pulse dma_done -> irq=1, STATUS reads 0x2; write STATUS=0x2 -> irq=0; W1C coincident with dma_done -> done remains 1.
REQ-036 Write 0x14 and 0x20, read 0x20 -> bresp 2'b10 both, rdata 0, rresp 2'b10; VERSION read still 0x0001_0000.
REQ-037 Hold bready=0 for 5 cycles after a write -> bvalid stays 1, awready/wready stay 0; assert rst mid-transaction -> all valids/readies 0 immediately.
REQ-038 With AXIL_DMA_REGS_WSTRB_EN: DST=0xFFFF_FFFF, write 0x1234_5678 wstrb=4'b0011 -> reads 0xFFFF_5678; without macro -> 0x1234_5678.
